// File: rtl/conv_window_gen.sv
// conv_window_gen
// Turns a raster-order pixel stream into every valid KxK window of the frame.
// K-1 line buffers hold the previous rows of each column, so every pixel is
// fetched once. A KxK shift window takes one new column per accepted pixel.
// A window is presented whenever the newest pixel is at row>=K-1 and col>=K-1.
module conv_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         win_valid,
    input  logic                         win_ready,
    output logic [K*K*DATA_WIDTH-1:0]    win_data,
    output logic [$clog2(IMG_H)-1:0]     win_row,
    output logic [$clog2(IMG_W)-1:0]     win_col,
    output logic                         busy,
    output logic                         done
);

    localparam int ROW_W    = $clog2(IMG_H);
    localparam int COL_W    = $clog2(IMG_W);
    localparam int NUM_PIX  = IMG_W * IMG_H;
    localparam int PIX_W    = $clog2(NUM_PIX + 1);
    localparam int NUM_WIN  = (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int WCNT_RAW = $clog2(NUM_WIN);
    localparam int WCNT_W   = (WCNT_RAW > 10) ? WCNT_RAW : 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ROW_W-1:0]  row_cnt;
    logic [COL_W-1:0]  col_cnt;
    logic [PIX_W-1:0]  pix_cnt;
    logic [WCNT_W-1:0] win_cnt;

    logic in_hs;
    logic out_hs;
    logic completes;
    logic last_win;

    // Previous K-1 rows per column: index 0 is the oldest row.
    logic [DATA_WIDTH-1:0] linebuf [K-1][IMG_W];
    // Column assembled from the line buffers plus the incoming pixel.
    logic [DATA_WIDTH-1:0] col_p0 [K];
    // Window registers: [row][col], row 0 oldest, col 0 leftmost.
    logic [DATA_WIDTH-1:0] win_p1 [K][K];

    // Pixels are only taken while a frame runs, pixels remain, and the
    // window slot is empty or being emptied this cycle.
    assign in_ready  = (state == RUN) && (pix_cnt < PIX_W'(NUM_PIX)) &&
                       (!win_valid || win_ready);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = win_valid && win_ready;
    assign completes = (row_cnt >= ROW_W'(K - 1)) && (col_cnt >= COL_W'(K - 1));
    assign last_win  = (win_cnt == WCNT_W'(NUM_WIN - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (out_hs && last_win) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster position of the next pixel, pixels taken and windows delivered.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
            pix_cnt <= '0;
            win_cnt <= '0;
        end else if (state == IDLE && start) begin
            row_cnt <= '0;
            col_cnt <= '0;
            pix_cnt <= '0;
            win_cnt <= '0;
        end else begin
            if (in_hs) begin
                pix_cnt <= pix_cnt + PIX_W'(1);
                if (col_cnt == COL_W'(IMG_W - 1)) begin
                    col_cnt <= '0;
                    if (row_cnt == ROW_W'(IMG_H - 1)) begin
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + ROW_W'(1);
                    end
                end else begin
                    col_cnt <= col_cnt + COL_W'(1);
                end
            end
            if (out_hs) begin
                win_cnt <= win_cnt + WCNT_W'(1);
            end
        end
    end

    // Stage 0: new column = buffered rows of this column on top, pixel at bottom.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            col_p0[i] = linebuf[i][col_cnt];
        end
        col_p0[K-1] = in_data;
    end

    // Line buffers age one row per accepted pixel in that column; never reset.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            for (int i = 0; i < K - 2; i++) begin
                linebuf[i][col_cnt] <= linebuf[i+1][col_cnt];
            end
            linebuf[K-2][col_cnt] <= in_data;
        end
    end

    // Stage 1: window shifts left one column and takes the new column on the right.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_p1[r][c] <= '0;
                end
            end
        end else if (in_hs) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win_p1[r][c] <= win_p1[r][c+1];
                end
                win_p1[r][K-1] <= col_p0[r];
            end
        end
    end

    // Window valid flag and top-left coordinates; held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else if (in_hs && completes) begin
            win_valid <= 1'b1;
            win_row   <= row_cnt - ROW_W'(K - 1);
            win_col   <= col_cnt - COL_W'(K - 1);
        end else if (out_hs) begin
            win_valid <= 1'b0;
        end
    end

    // Flatten window registers: element (r,c) at slot r*K+c.
    always_comb begin
        win_data = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_data[(r*K + c)*DATA_WIDTH +: DATA_WIDTH] = win_p1[r][c];
            end
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: directed frames (ramp, random data, stall,
// input gaps, mid-frame start, abort by reset) checked every cycle against
// a frame-level model plus hand-computed literal expectations.
module tb_conv_window_gen;

    localparam int DATA_WIDTH   = 16;
    localparam int IMG_W        = 32;
    localparam int IMG_H        = 32;
    localparam int K            = 5;
    localparam int NUM_PIX      = IMG_W * IMG_H;
    localparam int OUT_W        = IMG_W - K + 1;
    localparam int OUT_H        = IMG_H - K + 1;
    localparam int NUM_WIN      = OUT_W * OUT_H;
    localparam int WIN_BITS     = K * K * DATA_WIDTH;
    localparam int FRAME_BUDGET = 8000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  win_valid;
    logic                  win_ready;
    logic [WIN_BITS-1:0]   win_data;
    logic [4:0]            win_row;
    logic [4:0]            win_col;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH(DATA_WIDTH),
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .K(K)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_data(win_data),
        .win_row(win_row),
        .win_col(win_col),
        .busy(busy),
        .done(done)
    );

    // Frame image being streamed; the model derives windows from it directly.
    logic [DATA_WIDTH-1:0] img [IMG_H][IMG_W];
    bit is_ramp = 1'b0;
    bit chk_en  = 1'b0;

    // Model state
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_pix = 0;
    int m_completed = 0;
    int m_taken = 0;
    int m_prev_acc = -1;
    int m_dones = 0;
    int m_cyc = 0;
    int t_first = 0;
    int t_done = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic check_data(input bit ok, input string name,
                              input logic [WIN_BITS-1:0] act, input logic [WIN_BITS-1:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [WIN_BITS-1:0] exp_window(input int w);
        logic [WIN_BITS-1:0] v;
        int r0;
        int c0;
        r0 = w / OUT_W;
        c0 = w % OUT_W;
        v = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                v[(r*K + c)*DATA_WIDTH +: DATA_WIDTH] = img[r0 + r][c0 + c];
        return v;
    endfunction

    function automatic int elem(input logic [WIN_BITS-1:0] v, input int r, input int c);
        return int'(v[(r*K + c)*DATA_WIDTH +: DATA_WIDTH]);
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin : cmp
        bit exp_valid;
        bit exp_run;
        bit exp_in_ready;
        bit acc;
        bit tk;
        int w;
        m_cyc++;
        exp_valid    = (m_completed > m_taken);
        exp_run      = m_busy && !m_done;
        exp_in_ready = exp_run && (m_pix < NUM_PIX) && (!exp_valid || win_ready);
        if (chk_en) begin
            check(busy === m_busy, "busy", busy, m_busy);
            check(done === m_done, "done", done, m_done);
            check(win_valid === exp_valid, "win_valid", win_valid, exp_valid);
            check(in_ready === exp_in_ready, "in_ready", in_ready, exp_in_ready);
            if (exp_valid && win_valid === 1'b1) begin
                w = m_taken;
                check(win_row === 5'(w / OUT_W), "win_row", win_row, w / OUT_W);
                check(win_col === 5'(w % OUT_W), "win_col", win_col, w % OUT_W);
                check_data(win_data === exp_window(w), "win_data", win_data, exp_window(w));
            end
            if (m_prev_acc == 132) begin
                check(win_valid === 1'b1, "first_win_latency", win_valid, 1);
                check(win_row === 5'd0 && win_col === 5'd0, "first_win_pos", {win_row, win_col}, 0);
                if (is_ramp) begin
                    check(elem(win_data, 0, 0) == 0, "first_win_00", elem(win_data, 0, 0), 0);
                    check(elem(win_data, 4, 4) == 132, "first_win_44", elem(win_data, 4, 4), 132);
                end
            end
            if (m_prev_acc == 163)
                check(win_valid === 1'b0, "row_boundary_gap", win_valid, 0);
            if (m_prev_acc == 164) begin
                check(win_valid === 1'b1, "row1_win_valid", win_valid, 1);
                check(win_row === 5'd1, "row1_win_row", win_row, 1);
                check(win_col === 5'd0, "row1_win_col", win_col, 0);
                if (is_ramp)
                    check(elem(win_data, 0, 0) == 32, "row1_win_00", elem(win_data, 0, 0), 32);
            end
            if (is_ramp && exp_valid && m_taken == NUM_WIN - 1) begin
                check(elem(win_data, 0, 0) == 891, "last_win_00", elem(win_data, 0, 0), 891);
                check(elem(win_data, 4, 4) == 1023, "last_win_44", elem(win_data, 4, 4), 1023);
                check(win_row === 5'd27 && win_col === 5'd27, "last_win_pos", {win_row, win_col}, {5'd27, 5'd27});
            end
        end
        acc = in_valid && exp_in_ready;
        tk  = exp_valid && win_ready;
        m_prev_acc = -1;
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_pix = 0;
            m_completed = 0;
            m_taken = 0;
        end else if (m_done) begin
            m_done = 1'b0;
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1'b1;
                m_pix = 0;
                m_completed = 0;
                m_taken = 0;
            end
        end else begin
            if (acc) begin
                if ((m_pix / IMG_W) >= K - 1 && (m_pix % IMG_W) >= K - 1)
                    m_completed++;
                if (m_pix == 0)
                    t_first = m_cyc;
                m_prev_acc = m_pix;
                m_pix++;
            end
            if (tk) begin
                m_taken++;
                if (m_taken == NUM_WIN)
                    m_done = 1'b1;
            end
        end
        if (chk_en && done === 1'b1) begin
            m_dones++;
            t_done = m_cyc;
        end
    end

    task automatic fill_ramp();
        is_ramp = 1'b1;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = DATA_WIDTH'(r * 32 + c);
    endtask

    task automatic fill_random();
        is_ramp = 1'b0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                img[r][c] = DATA_WIDTH'($urandom);
    endtask

    task automatic run_frame(input int valid_pct, input int ready_pct, input bit do_stall,
                             input bit mid_start, input int abort_at, input bit check_timing);
        int idx;
        int cyc;
        int wins;
        int stall_left;
        bit stalled;
        bit snap_ok;
        bit acc;
        bit seen_done;
        logic [WIN_BITS-1:0] snap_d;
        logic [4:0] snap_r;
        logic [4:0] snap_c;
        idx = 0; cyc = 0; wins = 0; stall_left = 0;
        stalled = 0; snap_ok = 0; seen_done = 0;
        snap_d = '0; snap_r = '0; snap_c = '0;
        m_dones = 0;
        start = 1'b1; in_valid = 1'b0; win_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!seen_done && cyc < FRAME_BUDGET) begin
            if (abort_at >= 0 && idx == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                check(in_ready === 1'b0, "abort_in_ready", in_ready, 0);
                check(win_valid === 1'b0, "abort_win_valid", win_valid, 0);
                check_data(win_data === '0, "abort_win_data", win_data, '0);
                check(win_row === 5'd0 && win_col === 5'd0, "abort_win_pos", {win_row, win_col}, 0);
                check(busy === 1'b0, "abort_busy", busy, 0);
                check(done === 1'b0, "abort_done", done, 0);
                repeat (20) @(posedge clk);
                #1;
                check(m_dones == 0, "abort_no_done", m_dones, 0);
                return;
            end
            in_valid = (idx < NUM_PIX) && ($urandom_range(99) < valid_pct);
            in_data  = (idx < NUM_PIX) ? img[idx / IMG_W][idx % IMG_W] : '0;
            if (stall_left > 0) win_ready = 1'b0;
            else win_ready = ($urandom_range(99) < ready_pct);
            start = mid_start && (cyc == 300);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (win_valid && win_ready) wins++;
            if (stall_left > 0) begin
                if (win_valid === 1'b1) begin
                    check(in_ready === 1'b0, "stall_in_ready", in_ready, 0);
                    if (snap_ok) begin
                        check_data(win_data === snap_d, "stall_win_data", win_data, snap_d);
                        check(win_row === snap_r, "stall_win_row", win_row, snap_r);
                        check(win_col === snap_c, "stall_win_col", win_col, snap_c);
                    end else begin
                        snap_ok = 1'b1;
                        snap_d = win_data;
                        snap_r = win_row;
                        snap_c = win_col;
                    end
                end
                stall_left--;
            end
            if (do_stall && !stalled && wins == 100) begin
                stalled = 1'b1;
                stall_left = 10;
            end
            if (done === 1'b1) seen_done = 1'b1;
            @(posedge clk); #1;
            if (acc) idx++;
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        win_ready = 1'b1;
        if (!seen_done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=no_done required=done within %0d cycles", FRAME_BUDGET);
        end
        check(wins == NUM_WIN, "window_count", wins, NUM_WIN);
        repeat (3) @(posedge clk);
        #1;
        check(m_dones == 1, "done_pulses", m_dones, 1);
        if (check_timing)
            check(t_done - t_first == NUM_PIX + 1, "frame_cycles", t_done - t_first, NUM_PIX + 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        win_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        check(in_ready === 1'b0, "reset_in_ready", in_ready, 0);
        check(win_valid === 1'b0, "reset_win_valid", win_valid, 0);
        check_data(win_data === '0, "reset_win_data", win_data, '0);
        check(win_row === 5'd0, "reset_win_row", win_row, 0);
        check(win_col === 5'd0, "reset_win_col", win_col, 0);
        check(busy === 1'b0, "reset_busy", busy, 0);
        check(done === 1'b0, "reset_done", done, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        fill_ramp();
        run_frame(100, 100, 1'b0, 1'b0, -1, 1'b1);

        fill_random();
        run_frame(100, 100, 1'b1, 1'b1, -1, 1'b0);

        fill_ramp();
        run_frame(50, 100, 1'b0, 1'b0, -1, 1'b0);

        fill_random();
        run_frame(70, 60, 1'b0, 1'b1, -1, 1'b0);

        fill_ramp();
        run_frame(100, 100, 1'b0, 1'b0, 500, 1'b0);

        run_frame(100, 100, 1'b0, 1'b0, -1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
